// File: rtl/entry_buffer_pkg.sv
// rtl/entry_buffer_pkg.sv - shared types and per-entry helper functions for entry_buffer
// Used with the optional ENTRY_BUFFER_FORWARD_EN build macro (see entry_buffer.sv).
package entry_buffer_pkg;

    localparam int BUF_SIZE = 8;
    localparam int INDEX_W  = $clog2(BUF_SIZE);

    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [4:0]         tag_t;
    typedef logic [5:0]         spectag_t;

    typedef enum logic [1:0] {
        S_NOT_USED     = 2'd0,
        S_NOT_EXECUTED = 2'd1,
        S_EXECUTING    = 2'd2,
        S_EXECUTED     = 2'd3
    } e_state_t;

    typedef enum logic [1:0] {
        OP_ALU    = 2'd0,
        OP_LOAD   = 2'd1,
        OP_STORE  = 2'd2,
        OP_BRANCH = 2'd3
    } op_t;

    // An all-zero entry is exactly an unused slot.
    typedef struct packed {
        e_state_t    e_state;
        op_t         op;
        tag_t        tag;
        tag_t        qj;
        tag_t        qk;
        logic        j_rdy;
        logic        k_rdy;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] result;
        spectag_t    speculative_tag;
        spectag_t    specific_speculative_tag;
        logic [2:0]  number_of_early_store_ops;
    } entry_t;

    function automatic entry_t apply_wakeup(input entry_t e, input logic [1:0] cdb_valid,
                                            input tag_t [1:0] cdb_tag,
                                            input logic [1:0][31:0] cdb_value);
        entry_t r;
        r = e;
        if (e.e_state != S_NOT_USED) begin
            // Port 1 first so that port 0 overrides it on a shared tag.
            for (int p = 1; p >= 0; p--) begin
                if (cdb_valid[p] && !e.j_rdy && e.qj == cdb_tag[p]) begin
                    r.vj    = cdb_value[p];
                    r.j_rdy = 1'b1;
                    r.qj    = '0;
                end
                if (cdb_valid[p] && !e.k_rdy && e.qk == cdb_tag[p]) begin
                    r.vk    = cdb_value[p];
                    r.k_rdy = 1'b1;
                    r.qk    = '0;
                end
            end
        end
        return r;
    endfunction

    function automatic entry_t apply_branch(input entry_t e, input logic br_valid,
                                            input logic br_mispredict, input spectag_t br_spectag);
        entry_t r;
        r = e;
        if (br_valid) begin
            if (br_mispredict) begin
                if ((e.speculative_tag & br_spectag) != '0) r = '0;
            end else begin
                r.speculative_tag = e.speculative_tag & ~br_spectag;
            end
        end
        return r;
    endfunction

    function automatic entry_t apply_store_dec(input entry_t e, input logic [1:0] n_store);
        entry_t r;
        r = e;
        r.number_of_early_store_ops = (e.number_of_early_store_ops > 3'(n_store)) ?
                                      e.number_of_early_store_ops - 3'(n_store) : 3'd0;
        return r;
    endfunction

endpackage

// File: rtl/entry_buffer_entry_update.sv
// rtl/entry_buffer_entry_update.sv - per-slot wakeup, issue, result capture and branch resolution
// Produces the slot's next value before compaction and store-count adjustment.
module entry_update
    import entry_buffer_pkg::*;
(
    input  entry_t               cur,
    input  logic                 issue_hit,
    input  logic [1:0]           cdb_valid,
    input  tag_t [1:0]           cdb_tag,
    input  logic [1:0][31:0]     cdb_value,
    input  logic                 br_valid,
    input  logic                 br_mispredict,
    input  spectag_t             br_spectag,
    output entry_t               nxt,
    output logic                 squash
);

    always_comb begin
        nxt = apply_wakeup(cur, cdb_valid, cdb_tag, cdb_value);
        if (issue_hit && cur.e_state == S_NOT_EXECUTED && cur.j_rdy && cur.k_rdy)
            nxt.e_state = S_EXECUTING;
        if (cur.e_state == S_EXECUTING) begin
            for (int p = 1; p >= 0; p--) begin
                if (cdb_valid[p] && cdb_tag[p] == cur.tag) begin
                    nxt.e_state = S_EXECUTED;
                    nxt.result  = cdb_value[p];
                end
            end
        end
        nxt = apply_branch(nxt, br_valid, br_mispredict, br_spectag);
    end

    assign squash = br_valid && br_mispredict && ((cur.speculative_tag & br_spectag) != '0);

endmodule

// File: rtl/entry_buffer.sv
// rtl/entry_buffer.sv - in-order window of in-flight entries with dual dispatch, issue, CDB and commit
// Optional ENTRY_BUFFER_FORWARD_EN: dispatched entries capture same-cycle CDB results.
module entry_buffer
    import entry_buffer_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  disp_valid,
    input  index_t [1:0]                disp_index,
    input  entry_t [1:0]                disp_entry,
    input  logic [1:0]                  issue_valid,
    input  index_t [1:0]                issue_index,
    input  logic [1:0]                  cdb_valid,
    input  tag_t [1:0]                  cdb_tag,
    input  logic [1:0][31:0]            cdb_value,
    input  logic                        br_valid,
    input  logic                        br_mispredict,
    input  spectag_t                    br_spectag,
    output logic [1:0]                  commit_valid,
    output entry_t [1:0]                commit_entry,
    output entry_t [BUF_SIZE-1:0]       entries_all
);

    entry_t [BUF_SIZE-1:0] entries;
    entry_t [BUF_SIZE-1:0] upd;
    entry_t [BUF_SIZE-1:0] next;
    entry_t [BUF_SIZE+1:0] shift_src;
    entry_t [1:0]          new_entry;
    logic   [BUF_SIZE-1:0] squash;
    logic   [BUF_SIZE-1:0] issue_hit;
    logic   [1:0]          n_commit;
    logic   [1:0]          n_store;

    for (genvar i = 0; i < BUF_SIZE; i++) begin : g_slot
        assign issue_hit[i] = (issue_valid[0] && issue_index[0] == index_t'(i)) ||
                              (issue_valid[1] && issue_index[1] == index_t'(i));
        entry_update u_entry_update (
            .cur           (entries[i]),
            .issue_hit     (issue_hit[i]),
            .cdb_valid     (cdb_valid),
            .cdb_tag       (cdb_tag),
            .cdb_value     (cdb_value),
            .br_valid      (br_valid),
            .br_mispredict (br_mispredict),
            .br_spectag    (br_spectag),
            .nxt           (upd[i]),
            .squash        (squash[i])
        );
    end

    always_comb begin
        commit_valid    = '0;
        commit_valid[0] = entries[0].e_state == S_EXECUTED && entries[0].speculative_tag == '0 &&
                          !squash[0];
        commit_valid[1] = commit_valid[0] && entries[1].e_state == S_EXECUTED &&
                          entries[1].speculative_tag == '0 && !squash[1];
        commit_entry[0] = commit_valid[0] ? entries[0] : '0;
        commit_entry[1] = commit_valid[1] ? entries[1] : '0;
    end

    assign n_commit = {1'b0, commit_valid[0]} + {1'b0, commit_valid[1]};
    assign n_store  = {1'b0, commit_valid[0] && entries[0].op == OP_STORE} +
                      {1'b0, commit_valid[1] && entries[1].op == OP_STORE};

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            new_entry[k]         = disp_entry[k];
            new_entry[k].e_state = S_NOT_EXECUTED;
`ifdef ENTRY_BUFFER_FORWARD_EN
            new_entry[k] = apply_wakeup(new_entry[k], cdb_valid, cdb_tag, cdb_value);
`endif
            new_entry[k] = apply_branch(new_entry[k], br_valid, br_mispredict, br_spectag);
        end
    end

    // Two zero entries above the top refill the slots vacated by compaction.
    assign shift_src = {entry_t'('0), entry_t'('0), upd};

    always_comb begin
        next = '0;
        for (int i = 0; i < BUF_SIZE; i++)
            next[i] = shift_src[i + int'(n_commit)];
        for (int k = 0; k < 2; k++)
            if (disp_valid[k])
                next[disp_index[k] - index_t'(n_commit)] = new_entry[k];
        for (int i = 0; i < BUF_SIZE; i++)
            next[i] = apply_store_dec(next[i], n_store);
    end

    always_ff @(posedge clk) begin
        if (reset) entries <= '0;
        else       entries <= next;
    end

    assign entries_all = entries;

    a_disp0_free: assert property (@(posedge clk) disable iff (reset)
        disp_valid[0] |-> entries[disp_index[0]].e_state == S_NOT_USED);
    a_disp1_free: assert property (@(posedge clk) disable iff (reset)
        disp_valid[1] |-> entries[disp_index[1]].e_state == S_NOT_USED);

endmodule

// File: tb/tb_entry_buffer.sv
// tb/tb_entry_buffer.sv - directed and randomized self-checking bench for entry_buffer
// Honours ENTRY_BUFFER_FORWARD_EN when the design is built with it.
module tb_entry_buffer;
    import entry_buffer_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [1:0]            disp_valid;
    index_t [1:0]          disp_index;
    entry_t [1:0]          disp_entry;
    logic [1:0]            issue_valid;
    index_t [1:0]          issue_index;
    logic [1:0]            cdb_valid;
    tag_t [1:0]            cdb_tag;
    logic [1:0][31:0]      cdb_value;
    logic                  br_valid;
    logic                  br_mispredict;
    spectag_t              br_spectag;
    logic [1:0]            commit_valid;
    entry_t [1:0]          commit_entry;
    entry_t [BUF_SIZE-1:0] entries_all;

    int checks = 0;
    int errors = 0;
    entry_t m [BUF_SIZE];

    entry_buffer dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_index(disp_index), .disp_entry(disp_entry),
        .issue_valid(issue_valid), .issue_index(issue_index),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .br_valid(br_valid), .br_mispredict(br_mispredict), .br_spectag(br_spectag),
        .commit_valid(commit_valid), .commit_entry(commit_entry), .entries_all(entries_all)
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(input tag_t tag, input op_t op, input tag_t qj, input logic j_rdy,
                                  input tag_t qk, input logic k_rdy, input spectag_t spec,
                                  input logic [2:0] early);
        entry_t e;
        e = '0;
        e.tag = tag; e.op = op; e.qj = qj; e.j_rdy = j_rdy; e.qk = qk; e.k_rdy = k_rdy;
        e.speculative_tag = spec; e.number_of_early_store_ops = early;
        return e;
    endfunction

    // Reference model: operand wakeup from the broadcast, port 0 preferred.
    function automatic entry_t m_wake(input entry_t e);
        entry_t r;
        r = e;
        if (e.e_state == S_NOT_USED) return r;
        if (!e.j_rdy) begin
            if (cdb_valid[0] && cdb_tag[0] == e.qj) begin r.vj = cdb_value[0]; r.j_rdy = 1; r.qj = 0; end
            else if (cdb_valid[1] && cdb_tag[1] == e.qj) begin r.vj = cdb_value[1]; r.j_rdy = 1; r.qj = 0; end
        end
        if (!e.k_rdy) begin
            if (cdb_valid[0] && cdb_tag[0] == e.qk) begin r.vk = cdb_value[0]; r.k_rdy = 1; r.qk = 0; end
            else if (cdb_valid[1] && cdb_tag[1] == e.qk) begin r.vk = cdb_value[1]; r.k_rdy = 1; r.qk = 0; end
        end
        return r;
    endfunction

    function automatic entry_t m_resolve(input entry_t e);
        entry_t r;
        r = e;
        if (!br_valid) return r;
        if (br_mispredict) return ((e.speculative_tag & br_spectag) != 0) ? entry_t'('0) : e;
        r.speculative_tag = e.speculative_tag & ~br_spectag;
        return r;
    endfunction

    function automatic entry_t m_evolve(input entry_t e, input int slot);
        entry_t r;
        bit granted;
        r = m_wake(e);
        granted = (issue_valid[0] && int'(issue_index[0]) == slot) ||
                  (issue_valid[1] && int'(issue_index[1]) == slot);
        if (granted && e.e_state == S_NOT_EXECUTED && e.j_rdy && e.k_rdy) r.e_state = S_EXECUTING;
        if (e.e_state == S_EXECUTING) begin
            if (cdb_valid[0] && cdb_tag[0] == e.tag) begin r.e_state = S_EXECUTED; r.result = cdb_value[0]; end
            else if (cdb_valid[1] && cdb_tag[1] == e.tag) begin r.e_state = S_EXECUTED; r.result = cdb_value[1]; end
        end
        return m_resolve(r);
    endfunction

    // Advance the model and the DUT by one clock with the currently driven inputs.
    task automatic step();
        entry_t nx [BUF_SIZE];
        entry_t q [$];
        entry_t e;
        int n, nst;
        n = 0; nst = 0;
        for (int c = 0; c < 2; c++)
            if (c == n && m[c].e_state == S_EXECUTED && m[c].speculative_tag == 0) begin
                n++;
                if (m[c].op == OP_STORE) nst++;
            end
        for (int i = n; i < BUF_SIZE; i++) q.push_back(m_evolve(m[i], i));
        while (q.size() < BUF_SIZE) q.push_back(entry_t'('0));
        for (int i = 0; i < BUF_SIZE; i++) nx[i] = q[i];
        for (int k = 0; k < 2; k++)
            if (disp_valid[k]) begin
                e = disp_entry[k];
                e.e_state = S_NOT_EXECUTED;
`ifdef ENTRY_BUFFER_FORWARD_EN
                e = m_wake(e);
`endif
                nx[int'(disp_index[k]) - n] = m_resolve(e);
            end
        for (int i = 0; i < BUF_SIZE; i++)
            nx[i].number_of_early_store_ops = (int'(nx[i].number_of_early_store_ops) > nst) ?
                3'(int'(nx[i].number_of_early_store_ops) - nst) : 3'd0;
        if (reset) for (int i = 0; i < BUF_SIZE; i++) nx[i] = '0;
        @(posedge clk);
        #1;
        m = nx;
    endtask

    task automatic idle();
        reset = 0; disp_valid = 0; disp_index = '0; disp_entry = '0;
        issue_valid = 0; issue_index = '0; cdb_valid = 0; cdb_tag = '0; cdb_value = '0;
        br_valid = 0; br_mispredict = 0; br_spectag = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (commit_valid !== 2'b00) begin errors++; $display("FAIL reset_commit_valid got %b exp 00", commit_valid); end
        checks++;
        if (commit_entry !== '0) begin errors++; $display("FAIL reset_commit_entry got %h exp 0", commit_entry); end
        for (int i = 0; i < BUF_SIZE; i++) begin
            checks++;
            if (entries_all[i] !== '0) begin errors++; $display("FAIL reset_slot%0d got %h exp 0", i, entries_all[i]); end
        end
    endtask

    task automatic test_dispatch();
        do_reset();
        disp_valid = 2'b11;
        disp_index[0] = 3; disp_entry[0] = mk(5'd1, OP_ALU, 5'd9, 0, 5'd0, 1, 6'd0, 3'd0);
        disp_index[1] = 2; disp_entry[1] = mk(5'd2, OP_ALU, 5'd0, 1, 5'd0, 1, 6'd0, 3'd0);
        step();
        idle();
        for (int i = 0; i < BUF_SIZE; i++) begin
            checks++;
            if (entries_all[i].e_state !== ((i == 2 || i == 3) ? S_NOT_EXECUTED : S_NOT_USED)) begin
                errors++; $display("FAIL dispatch_state slot%0d got %0d", i, entries_all[i].e_state);
            end
        end
        checks++;
        if (entries_all[3].tag !== 5'd1) begin errors++; $display("FAIL dispatch_tag got %0d exp 1", entries_all[3].tag); end
    endtask

    task automatic test_wakeup();
        do_reset();
        disp_valid = 2'b01; disp_index[0] = 0;
        disp_entry[0] = mk(5'd3, OP_ALU, 5'b01111, 0, 5'd0, 1, 6'd0, 3'd0);
        step();
        idle();
        cdb_valid = 2'b01; cdb_tag[0] = 5'b01111; cdb_value[0] = 32'hDEAD_BEEF;
        step();
        idle();
        checks++;
        if (entries_all[0].vj !== 32'hDEAD_BEEF || entries_all[0].j_rdy !== 1'b1 || entries_all[0].qj !== 5'd0) begin
            errors++; $display("FAIL wakeup got vj=%h rdy=%b qj=%0d exp deadbeef 1 0",
                               entries_all[0].vj, entries_all[0].j_rdy, entries_all[0].qj);
        end
    endtask

    task automatic test_commit_compact();
        do_reset();
        disp_valid = 2'b11;
        disp_index[0] = 0; disp_entry[0] = mk(5'd1, OP_ALU, 5'd0, 1, 5'd0, 1, 6'd0, 3'd0);
        disp_index[1] = 1; disp_entry[1] = mk(5'd2, OP_ALU, 5'd0, 1, 5'd0, 1, 6'd0, 3'd0);
        step();
        idle();
        disp_valid = 2'b01; disp_index[0] = 2; disp_entry[0] = mk(5'd3, OP_ALU, 5'd9, 0, 5'd0, 1, 6'd0, 3'd0);
        issue_valid = 2'b11; issue_index[0] = 0; issue_index[1] = 1;
        step();
        idle();
        cdb_valid = 2'b11; cdb_tag[0] = 5'd1; cdb_value[0] = 32'd100; cdb_tag[1] = 5'd2; cdb_value[1] = 32'd200;
        step();
        idle();
        checks++;
        if (commit_valid !== 2'b11) begin errors++; $display("FAIL commit_valid got %b exp 11", commit_valid); end
        checks++;
        if (commit_entry[0].result !== 32'd100 || commit_entry[1].tag !== 5'd2) begin
            errors++; $display("FAIL commit_entry got res=%0d tag=%0d exp 100 2", commit_entry[0].result, commit_entry[1].tag);
        end
        disp_valid = 2'b01; disp_index[0] = 4; disp_entry[0] = mk(5'd4, OP_ALU, 5'd0, 1, 5'd0, 1, 6'd0, 3'd0);
        step();
        idle();
        checks++;
        if (entries_all[0].tag !== 5'd3 || entries_all[0].e_state !== S_NOT_EXECUTED) begin
            errors++; $display("FAIL compact_slot0 got tag=%0d st=%0d exp 3 1", entries_all[0].tag, entries_all[0].e_state);
        end
        checks++;
        if (entries_all[2].tag !== 5'd4 || entries_all[2].e_state !== S_NOT_EXECUTED) begin
            errors++; $display("FAIL compact_new got tag=%0d st=%0d exp 4 1", entries_all[2].tag, entries_all[2].e_state);
        end
        for (int i = 3; i < BUF_SIZE; i++) begin
            checks++;
            if (entries_all[i].e_state !== S_NOT_USED) begin errors++; $display("FAIL compact_top slot%0d got %0d exp 0", i, entries_all[i].e_state); end
        end
    endtask

    task automatic test_squash();
        do_reset();
        disp_valid = 2'b11;
        disp_index[0] = 0; disp_entry[0] = mk(5'd1, OP_ALU, 5'd9, 0, 5'd0, 1, 6'b000001, 3'd0);
        disp_index[1] = 1; disp_entry[1] = mk(5'd2, OP_ALU, 5'd9, 0, 5'd0, 1, 6'b000011, 3'd0);
        step();
        idle();
        disp_valid = 2'b01; disp_index[0] = 2; disp_entry[0] = mk(5'd3, OP_ALU, 5'd9, 0, 5'd0, 1, 6'b000010, 3'd0);
        step();
        idle();
        br_valid = 1; br_mispredict = 1; br_spectag = 6'b000001;
        disp_valid = 2'b01; disp_index[0] = 3; disp_entry[0] = mk(5'd4, OP_ALU, 5'd0, 1, 5'd0, 1, 6'b000001, 3'd0);
        step();
        idle();
        checks++;
        if (entries_all[0].e_state !== S_NOT_USED || entries_all[1].e_state !== S_NOT_USED) begin
            errors++; $display("FAIL squash_hit got %0d %0d exp 0 0", entries_all[0].e_state, entries_all[1].e_state);
        end
        checks++;
        if (entries_all[2].e_state !== S_NOT_EXECUTED) begin errors++; $display("FAIL squash_survivor got %0d exp 1", entries_all[2].e_state); end
        checks++;
        if (entries_all[3].e_state !== S_NOT_USED) begin errors++; $display("FAIL squash_new got %0d exp 0", entries_all[3].e_state); end
    endtask

    task automatic test_confirm();
        do_reset();
        disp_valid = 2'b01; disp_index[0] = 0;
        disp_entry[0] = mk(5'd6, OP_BRANCH, 5'd0, 1, 5'd0, 1, 6'b000010, 3'd0);
        disp_entry[0].specific_speculative_tag = 6'b000010;
        step();
        idle();
        issue_valid = 2'b10; issue_index[1] = 0;
        step();
        idle();
        cdb_valid = 2'b10; cdb_tag[1] = 5'd6; cdb_value[1] = 32'd7;
        step();
        idle();
        checks++;
        if (commit_valid !== 2'b00) begin errors++; $display("FAIL confirm_pre_commit got %b exp 00", commit_valid); end
        br_valid = 1; br_mispredict = 0; br_spectag = 6'b000010;
        step();
        idle();
        checks++;
        if (entries_all[0].speculative_tag !== 6'd0 || entries_all[0].specific_speculative_tag !== 6'b000010) begin
            errors++; $display("FAIL confirm_tags got %b %b exp 000000 000010",
                               entries_all[0].speculative_tag, entries_all[0].specific_speculative_tag);
        end
        checks++;
        if (commit_valid !== 2'b01) begin errors++; $display("FAIL confirm_commit got %b exp 01", commit_valid); end
    endtask

    task automatic test_store();
        do_reset();
        disp_valid = 2'b11;
        disp_index[0] = 0; disp_entry[0] = mk(5'd7, OP_STORE, 5'd0, 1, 5'd0, 1, 6'd0, 3'd0);
        disp_index[1] = 1; disp_entry[1] = mk(5'd8, OP_ALU, 5'd9, 0, 5'd0, 1, 6'd0, 3'd2);
        step();
        idle();
        issue_valid = 2'b01; issue_index[0] = 0;
        step();
        idle();
        cdb_valid = 2'b01; cdb_tag[0] = 5'd7;
        step();
        idle();
        checks++;
        if (commit_valid !== 2'b01) begin errors++; $display("FAIL store_commit got %b exp 01", commit_valid); end
        step();
        checks++;
        if (entries_all[0].tag !== 5'd8 || entries_all[0].number_of_early_store_ops !== 3'd1) begin
            errors++; $display("FAIL store_dec got tag=%0d cnt=%0d exp 8 1",
                               entries_all[0].tag, entries_all[0].number_of_early_store_ops);
        end
    endtask

    task automatic test_forward();
        do_reset();
        disp_valid = 2'b01; disp_index[0] = 0;
        disp_entry[0] = mk(5'd3, OP_ALU, 5'd0, 1, 5'b01110, 0, 6'd0, 3'd0);
        cdb_valid = 2'b01; cdb_tag[0] = 5'b01110; cdb_value[0] = 32'h1234_5678;
        step();
        idle();
        checks++;
`ifdef ENTRY_BUFFER_FORWARD_EN
        if (entries_all[0].k_rdy !== 1'b1 || entries_all[0].vk !== 32'h1234_5678 || entries_all[0].qk !== 5'd0) begin
            errors++; $display("FAIL forward got rdy=%b vk=%h qk=%0d exp 1 12345678 0",
                               entries_all[0].k_rdy, entries_all[0].vk, entries_all[0].qk);
        end
`else
        if (entries_all[0].k_rdy !== 1'b0 || entries_all[0].qk !== 5'b01110) begin
            errors++; $display("FAIL no_forward got rdy=%b qk=%0d exp 0 14", entries_all[0].k_rdy, entries_all[0].qk);
        end
`endif
    endtask

    task automatic test_random();
        int free [$];
        int pick, s;
        logic [1:0] exp_cv;
        entry_t e;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle();
            reset = ($urandom_range(0, 199) == 0);
            free.delete();
            for (int i = 0; i < BUF_SIZE; i++) if (m[i].e_state == S_NOT_USED) free.push_back(i);
            for (int k = 0; k < 2; k++) begin
                if (free.size() > 0 && $urandom_range(0, 1) == 1) begin
                    pick = $urandom_range(0, free.size() - 1);
                    disp_valid[k] = 1; disp_index[k] = index_t'(free[pick]);
                    free.delete(pick);
                    e = entry_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
                    e.tag = tag_t'($urandom_range(1, 15)); e.qj = tag_t'($urandom_range(1, 15));
                    e.qk = tag_t'($urandom_range(1, 15));
                    e.speculative_tag = ($urandom_range(0, 3) == 0) ? spectag_t'($urandom_range(1, 63)) : 6'd0;
                    disp_entry[k] = e;
                end
                if ($urandom_range(0, 1) == 1) begin issue_valid[k] = 1; issue_index[k] = index_t'($urandom_range(0, BUF_SIZE - 1)); end
                if ($urandom_range(0, 1) == 1) begin
                    s = $urandom_range(0, BUF_SIZE - 1);
                    case ($urandom_range(0, 2))
                        0: cdb_tag[k] = m[s].tag;
                        1: cdb_tag[k] = m[s].qj;
                        default: cdb_tag[k] = m[s].qk;
                    endcase
                    if (cdb_tag[k] == 0) cdb_tag[k] = tag_t'($urandom_range(1, 15));
                    cdb_valid[k] = 1; cdb_value[k] = $urandom;
                end
            end
            if ($urandom_range(0, 4) == 0) begin
                br_valid = 1; br_mispredict = ($urandom_range(0, 3) == 0);
                br_spectag = spectag_t'(1 << $urandom_range(0, 5));
            end
            #1;
            exp_cv = 2'b00;
            if (m[0].e_state == S_EXECUTED && m[0].speculative_tag == 0) begin
                exp_cv[0] = 1;
                if (m[1].e_state == S_EXECUTED && m[1].speculative_tag == 0) exp_cv[1] = 1;
            end
            checks++;
            if (commit_valid !== exp_cv) begin errors++; $display("FAIL rand_commit_valid cyc%0d got %b exp %b", cyc, commit_valid, exp_cv); end
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (commit_entry[c] !== (exp_cv[c] ? m[c] : entry_t'('0))) begin
                    errors++; $display("FAIL rand_commit_entry%0d cyc%0d got %h exp %h", c, cyc, commit_entry[c], m[c]);
                end
            end
            step();
            for (int i = 0; i < BUF_SIZE; i++) begin
                checks++;
                if (entries_all[i] !== m[i]) begin
                    errors++; $display("FAIL rand_slot%0d cyc%0d got %h exp %h", i, cyc, entries_all[i], m[i]);
                end
            end
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < BUF_SIZE; i++) m[i] = '0;
        idle();
        test_reset();
        test_dispatch();
        test_wakeup();
        test_commit_compact();
        test_squash();
        test_confirm();
        test_store();
        test_forward();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
